// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage core: shadow E/M/W destination pipeline,
// D-stage stall, D/E/M forwarding selects, and a stall-cycle counter.

module hazard_operand (
  input  logic [4:0] src_d,
  input  logic [2:0] t_use,
  input  logic [4:0] src_e,
  input  logic [4:0] dst_e,
  input  logic [2:0] tnew_e,
  input  logic [4:0] dst_m,
  input  logic [2:0] tnew_m,
  input  logic [4:0] dst_w,
  output logic       stall,
  output logic [1:0] fwd_d,
  output logic [1:0] fwd_e
);
  logic hit_e, hit_m, hit_w;
  logic hit_em, hit_ew;

  // $0 never matches: gate every compare on a nonzero source.
  assign hit_e  = (src_d != 5'd0) && (src_d == dst_e);
  assign hit_m  = (src_d != 5'd0) && (src_d == dst_m);
  assign hit_w  = (src_d != 5'd0) && (src_d == dst_w);
  assign hit_em = (src_e != 5'd0) && (src_e == dst_m);
  assign hit_ew = (src_e != 5'd0) && (src_e == dst_w);

  assign stall = (hit_e && (tnew_e > t_use)) || (hit_m && (tnew_m > t_use));

  always_comb begin
    fwd_d = 2'd0;
    if (hit_e && tnew_e == 3'd0)      fwd_d = 2'd1;
    else if (hit_m && tnew_m == 3'd0) fwd_d = 2'd2;
    else if (hit_w)                   fwd_d = 2'd3;
  end

  always_comb begin
    fwd_e = 2'd0;
    if (hit_em && tnew_m == 3'd0) fwd_e = 2'd1;
    else if (hit_ew)              fwd_e = 2'd2;
  end
endmodule

module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [2:0]       T_use_rs,
  input  logic [2:0]       T_use_rt,
  input  logic [4:0]       dst_d,
  input  logic [2:0]       tnew_d,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             fwd_rt_m,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NUM_OPS = 2;  // operand 0 = rs, 1 = rt

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [2:0] tnew;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] dst;
    logic [2:0] tnew;
  } m_stage_t;

  e_stage_t e_q, e_nxt;
  m_stage_t m_q, m_nxt;
  logic [4:0] dst_w;

  logic [NUM_OPS-1:0][4:0] src_d;
  logic [NUM_OPS-1:0][2:0] t_use;
  logic [NUM_OPS-1:0][4:0] src_e;
  logic [NUM_OPS-1:0]      stall_op;
  logic [NUM_OPS-1:0][1:0] fwd_d;
  logic [NUM_OPS-1:0][1:0] fwd_e;

  assign src_d = {rt_d, rs_d};
  assign t_use = {T_use_rt, T_use_rs};
  assign src_e = {e_q.rt, e_q.rs};

  genvar i;
  generate
    for (i = 0; i < NUM_OPS; i++) begin : g_op
      hazard_operand u_op (
        .src_d  (src_d[i]),
        .t_use  (t_use[i]),
        .src_e  (src_e[i]),
        .dst_e  (e_q.dst),
        .tnew_e (e_q.tnew),
        .dst_m  (m_q.dst),
        .tnew_m (m_q.tnew),
        .dst_w  (dst_w),
        .stall  (stall_op[i]),
        .fwd_d  (fwd_d[i]),
        .fwd_e  (fwd_e[i])
      );
    end
  endgenerate

  assign stall    = |stall_op;
  assign fwd_rs_d = fwd_d[0];
  assign fwd_rt_d = fwd_d[1];
  assign fwd_rs_e = fwd_e[0];
  assign fwd_rt_e = fwd_e[1];
  assign fwd_rt_m = (m_q.rt != 5'd0) && (m_q.rt == dst_w);

  // A stalled D instruction stays put; E gets an all-zero bubble instead.
  always_comb begin
    e_nxt = '0;
    if (!stall) begin
      e_nxt.rs   = rs_d;
      e_nxt.rt   = rt_d;
      e_nxt.dst  = dst_d;
      e_nxt.tnew = tnew_d;
    end
    m_nxt      = '0;
    m_nxt.rt   = e_q.rt;
    m_nxt.dst  = e_q.dst;
    m_nxt.tnew = (e_q.tnew == 3'd0) ? 3'd0 : e_q.tnew - 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q       <= '0;
      m_q       <= '0;
      dst_w     <= '0;
      stall_cnt <= '0;
    end else begin
      e_q       <= e_nxt;
      m_q       <= m_nxt;
      dst_w     <= m_q.dst;
      stall_cnt <= stall_cnt + CNT_W'(stall);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: canonical lw/ALU/jal/sw hazard sequences,
// $0 handling, and reset asserted in the middle of a stall.

module tb_hazard_unit;
  logic        clk;
  logic        reset;
  logic [4:0]  rs_d, rt_d, dst_d;
  logic [2:0]  T_use_rs, T_use_rt, tnew_d;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .T_use_rs(T_use_rs), .T_use_rt(T_use_rt),
    .dst_d(dst_d), .tnew_d(tnew_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a D instruction and let combinational outputs settle.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [2:0] tus, input logic [2:0] tut,
                       input logic [4:0] dst, input logic [2:0] tnew);
    rs_d = rs; rt_d = rt; T_use_rs = tus; T_use_rt = tut;
    dst_d = dst; tnew_d = tnew;
    #1;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 3'd3, 3'd3, 5'd0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b0;
    drive(5'd1, 5'd2, 3'd0, 3'd0, 5'd1, 3'd2);
    repeat (3) tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd_d", {28'd0, fwd_rs_d, fwd_rt_d}, 32'd0);
    chk("rst_fwd_e", {27'd0, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);

    reset = 1'b1;
    drain();
    chk("idle_cnt", stall_cnt, 32'd0);

    // lw $1 -> addu $2,$1,$3 : one bubble, then W->E forward
    drive(5'd2, 5'd0, 3'd1, 3'd3, 5'd1, 3'd2);
    chk("lw_nostall", {31'd0, stall}, 32'd0);
    tick();
    drive(5'd1, 5'd3, 3'd1, 3'd1, 5'd2, 3'd1);
    chk("lw_alu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lw_alu_release", {31'd0, stall}, 32'd0);
    chk("lw_alu_bubble_e", {30'd0, fwd_rs_e}, 32'd0);
    chk("lw_alu_cnt", stall_cnt, 32'd1);
    tick();
    nop();
    chk("lw_alu_fwd_rs_e", {30'd0, fwd_rs_e}, 32'd2);
    chk("lw_alu_fwd_rt_e", {30'd0, fwd_rt_e}, 32'd0);
    drain();

    // lw $5 -> beq $5,$0 : two stalls, then W->D forward
    drive(5'd0, 5'd0, 3'd3, 3'd3, 5'd5, 3'd2);
    tick();
    drive(5'd5, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0);
    chk("lw_beq_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("lw_beq_stall2", {31'd0, stall}, 32'd1);
    tick();
    chk("lw_beq_release", {31'd0, stall}, 32'd0);
    chk("lw_beq_fwd_rs_d", {30'd0, fwd_rs_d}, 32'd3);
    chk("lw_beq_fwd_rt_d", {30'd0, fwd_rt_d}, 32'd0);
    chk("lw_beq_cnt", stall_cnt, 32'd3);
    drain();

    // ori $4 -> beq $4,$4 : one stall, then M->D forward on both operands
    drive(5'd0, 5'd0, 3'd1, 3'd3, 5'd4, 3'd1);
    tick();
    drive(5'd4, 5'd4, 3'd0, 3'd0, 5'd0, 3'd0);
    chk("ori_beq_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("ori_beq_release", {31'd0, stall}, 32'd0);
    chk("ori_beq_fwd_rs_d", {30'd0, fwd_rs_d}, 32'd2);
    chk("ori_beq_fwd_rt_d", {30'd0, fwd_rt_d}, 32'd2);
    tick();
    nop();
    chk("ori_beq_cnt", stall_cnt, 32'd4);
    drain();

    // jal -> jr $31 : E->D forward, no stall
    drive(5'd0, 5'd0, 3'd3, 3'd3, 5'd31, 3'd0);
    tick();
    drive(5'd31, 5'd0, 3'd0, 3'd3, 5'd0, 3'd0);
    chk("jal_jr_stall", {31'd0, stall}, 32'd0);
    chk("jal_jr_fwd_rs_d", {30'd0, fwd_rs_d}, 32'd1);
    tick();
    // $0 producer with pending result, then $0 consumer
    drive(5'd0, 5'd0, 3'd3, 3'd3, 5'd0, 3'd2);
    tick();
    drive(5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0);
    chk("zero_stall", {31'd0, stall}, 32'd0);
    chk("zero_fwd_d", {28'd0, fwd_rs_d, fwd_rt_d}, 32'd0);
    chk("zero_fwd_e", {28'd0, fwd_rs_e, fwd_rt_e}, 32'd0);
    chk("zero_fwd_m", {31'd0, fwd_rt_m}, 32'd0);
    drain();

    // addu $1,$1,$1 never hazards against itself
    drive(5'd1, 5'd1, 3'd1, 3'd1, 5'd1, 3'd1);
    chk("self_stall", {31'd0, stall}, 32'd0);
    chk("self_fwd_d", {28'd0, fwd_rs_d, fwd_rt_d}, 32'd0);
    drain();

    // lw $7 -> sw $7 : no stall, store data forwarded W->M
    drive(5'd0, 5'd0, 3'd3, 3'd3, 5'd7, 3'd2);
    tick();
    drive(5'd0, 5'd7, 3'd1, 3'd2, 5'd0, 3'd0);
    chk("lw_sw_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    chk("lw_sw_fwd_rt_m_early", {31'd0, fwd_rt_m}, 32'd0);
    tick();
    chk("lw_sw_fwd_rt_m", {31'd0, fwd_rt_m}, 32'd1);
    chk("lw_sw_cnt", stall_cnt, 32'd4);
    drain();

    // reset asserted during a lw -> beq stall
    drive(5'd0, 5'd0, 3'd3, 3'd3, 5'd5, 3'd2);
    tick();
    drive(5'd5, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0);
    chk("midrst_stall_before", {31'd0, stall}, 32'd1);
    tick();
    chk("midrst_cnt_before", stall_cnt, 32'd5);
    reset = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_cnt", stall_cnt, 32'd0);
    tick();
    chk("midrst_hold_stall", {31'd0, stall}, 32'd0);
    chk("midrst_hold_cnt", stall_cnt, 32'd0);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
